// File: rtl/xosera_vram_arb_pkg.sv
// Shared types for the Xosera VRAM arbiter: access owner encoding and VRAM geometry.
package xosera_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_REG,
        OWN_BLT
    } vram_owner_t;

    localparam int VRAM_ADDR_W = 16;

    function automatic logic owner_is_port(input vram_owner_t owner);
        return (owner == OWN_REG) || (owner == OWN_BLT);
    endfunction

endpackage

// File: rtl/xosera_vram_arb_if.sv
// Bundle of requester and VRAM-side signals around xosera_vram_arb; the arbiter uses the slave view.
interface xosera_vram_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    localparam int MASK_W = DATA_W / 4;

    logic              vid_sel_i;
    logic [ADDR_W-1:0] vid_addr_i;
    logic [DATA_W-1:0] vid_data_o;

    logic              reg_req_i;
    logic              reg_wr_i;
    logic [MASK_W-1:0] reg_wr_mask_i;
    logic [ADDR_W-1:0] reg_addr_i;
    logic [DATA_W-1:0] reg_data_i;
    logic              reg_ack_o;

    logic              blit_req_i;
    logic              blit_wr_i;
    logic [MASK_W-1:0] blit_wr_mask_i;
    logic [ADDR_W-1:0] blit_addr_i;
    logic [DATA_W-1:0] blit_data_i;
    logic              blit_ack_o;

    logic [DATA_W-1:0] rd_data_o;

    logic              vram_sel_o;
    logic              vram_wr_o;
    logic [MASK_W-1:0] vram_wr_mask_o;
    logic [ADDR_W-1:0] vram_addr_o;
    logic [DATA_W-1:0] vram_data_o;
    logic [DATA_W-1:0] vram_data_i;

    modport master (
        output vid_sel_i, vid_addr_i,
        output reg_req_i, reg_wr_i, reg_wr_mask_i, reg_addr_i, reg_data_i,
        output blit_req_i, blit_wr_i, blit_wr_mask_i, blit_addr_i, blit_data_i,
        output vram_data_i,
        input  vid_data_o, reg_ack_o, blit_ack_o, rd_data_o,
        input  vram_sel_o, vram_wr_o, vram_wr_mask_o, vram_addr_o, vram_data_o
    );

    modport slave (
        input  vid_sel_i, vid_addr_i,
        input  reg_req_i, reg_wr_i, reg_wr_mask_i, reg_addr_i, reg_data_i,
        input  blit_req_i, blit_wr_i, blit_wr_mask_i, blit_addr_i, blit_data_i,
        input  vram_data_i,
        output vid_data_o, reg_ack_o, blit_ack_o, rd_data_o,
        output vram_sel_o, vram_wr_o, vram_wr_mask_o, vram_addr_o, vram_data_o
    );

endinterface

// File: rtl/xosera_vram_arb.sv
// VRAM arbiter: video has absolute priority, reg/blit share the remaining slots round-robin.
// Define XOSERA_BLIT_PORT_EN to enable the blitter port; otherwise reg owns every non-video slot.
module xosera_vram_arb
    import xosera_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = 16
) (
    input  logic             clk,
    input  logic             reset_n_i,
    xosera_vram_arb_if.slave bus
);

    localparam int MASK_W = DATA_W / 4;

    vram_owner_t       grant_s;
    vram_owner_t       own1_r;
    vram_owner_t       own2_r;
    logic              reg_elig_s;
    logic              blit_elig_s;
    logic              reg_busy_r;
    logic              sel_s;
    logic              wr_s;
    logic [MASK_W-1:0] mask_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic [DATA_W-1:0] rd_hold_r;
`ifdef XOSERA_BLIT_PORT_EN
    logic              blit_busy_r;
    logic              last_blit_r;
    logic              contested_s;
`endif

    // Arbitration decision for this cycle
    always_comb begin
        reg_elig_s = bus.reg_req_i & ~reg_busy_r;
`ifdef XOSERA_BLIT_PORT_EN
        blit_elig_s = bus.blit_req_i & ~blit_busy_r;
        contested_s = reg_elig_s & blit_elig_s & ~bus.vid_sel_i;
`else
        blit_elig_s = 1'b0;
`endif
        if (bus.vid_sel_i) begin
            grant_s = OWN_VID;
`ifdef XOSERA_BLIT_PORT_EN
        end else if (contested_s) begin
            // the port that lost the previous tie goes first
            grant_s = last_blit_r ? OWN_REG : OWN_BLT;
`endif
        end else if (reg_elig_s) begin
            grant_s = OWN_REG;
        end else if (blit_elig_s) begin
            grant_s = OWN_BLT;
        end else begin
            grant_s = OWN_NONE;
        end
    end

    // Operand steering for the granted port; address and data hold when idle
    always_comb begin
        sel_s  = 1'b1;
        wr_s   = 1'b0;
        mask_s = {MASK_W{1'b0}};
        addr_s = bus.vram_addr_o;
        data_s = bus.vram_data_o;
        case (grant_s)
            OWN_VID: begin
                addr_s = bus.vid_addr_i;
            end
            OWN_REG: begin
                wr_s   = bus.reg_wr_i;
                mask_s = bus.reg_wr_i ? bus.reg_wr_mask_i : {MASK_W{1'b0}};
                addr_s = bus.reg_addr_i;
                data_s = bus.reg_data_i;
            end
            OWN_BLT: begin
                wr_s   = bus.blit_wr_i;
                mask_s = bus.blit_wr_i ? bus.blit_wr_mask_i : {MASK_W{1'b0}};
                addr_s = bus.blit_addr_i;
                data_s = bus.blit_data_i;
            end
            default: begin
                sel_s = 1'b0;
            end
        endcase
    end

    // VRAM command registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bus.vram_sel_o     <= 1'b0;
            bus.vram_wr_o      <= 1'b0;
            bus.vram_wr_mask_o <= {MASK_W{1'b0}};
            bus.vram_addr_o    <= {ADDR_W{1'b0}};
            bus.vram_data_o    <= {DATA_W{1'b0}};
        end else begin
            bus.vram_sel_o     <= sel_s;
            bus.vram_wr_o      <= wr_s;
            bus.vram_wr_mask_o <= mask_s;
            bus.vram_addr_o    <= addr_s;
            bus.vram_data_o    <= data_s;
        end
    end

    // Owner pipeline, acks and busy tracking (busy spans grant through the ack cycle)
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            own1_r        <= OWN_NONE;
            own2_r        <= OWN_NONE;
            bus.reg_ack_o <= 1'b0;
            reg_busy_r    <= 1'b0;
        end else begin
            own1_r        <= grant_s;
            own2_r        <= own1_r;
            bus.reg_ack_o <= (own1_r == OWN_REG);
            if (grant_s == OWN_REG) begin
                reg_busy_r <= 1'b1;
            end else if (bus.reg_ack_o) begin
                reg_busy_r <= 1'b0;
            end else begin
                reg_busy_r <= reg_busy_r;
            end
        end
    end

`ifdef XOSERA_BLIT_PORT_EN
    // Blitter ack/busy and round-robin memory of the last contested winner
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bus.blit_ack_o <= 1'b0;
            blit_busy_r    <= 1'b0;
            last_blit_r    <= 1'b1;
        end else begin
            bus.blit_ack_o <= (own1_r == OWN_BLT);
            if (grant_s == OWN_BLT) begin
                blit_busy_r <= 1'b1;
            end else if (bus.blit_ack_o) begin
                blit_busy_r <= 1'b0;
            end else begin
                blit_busy_r <= blit_busy_r;
            end
            if (contested_s) begin
                last_blit_r <= (grant_s == OWN_BLT);
            end else begin
                last_blit_r <= last_blit_r;
            end
        end
    end
`else
    // Blitter port compiled out: never acknowledged
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bus.blit_ack_o <= 1'b0;
        end else begin
            bus.blit_ack_o <= 1'b0;
        end
    end
`endif

    // Read-data capture: video registered one cycle later, port data held between acks
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bus.vid_data_o <= {DATA_W{1'b0}};
            rd_hold_r      <= {DATA_W{1'b0}};
        end else begin
            if (own2_r == OWN_VID) begin
                bus.vid_data_o <= bus.vram_data_i;
            end else begin
                bus.vid_data_o <= bus.vid_data_o;
            end
            rd_hold_r <= bus.rd_data_o;
        end
    end

    // Port read data passes straight through in the ack cycle
    always_comb begin
        if (owner_is_port(own2_r)) begin
            bus.rd_data_o = bus.vram_data_i;
        end else begin
            bus.rd_data_o = rd_hold_r;
        end
    end

endmodule

// File: tb/tb_xosera_vram_arb.sv
// Self-checking bench for xosera_vram_arb: directed scenarios plus a randomized run against a schedule model.
module tb_xosera_vram_arb;

`ifdef XOSERA_BLIT_PORT_EN
    localparam bit BLIT_EN = 1'b1;
`else
    localparam bit BLIT_EN = 1'b0;
`endif
    localparam int NC = 600;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = 16'h0000;
    logic [15:0] pre_data = 16'h0000;
    int          n_checks = 0;
    int          n_pass = 0;

    xosera_vram_arb_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    xosera_vram_arb #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk      (clk),
        .reset_n_i(reset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [3:0] m);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[i*4 +: 4] = d[i*4 +: 4];
        return r;
    endfunction

    // VRAM behavioural model: registered read, masked write
    logic [15:0] vmem [0:65535];
    bit          vwr  [0:65535];

    function automatic logic [15:0] vram_rd(input logic [15:0] a);
        return vwr[a] ? vmem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (pre_en) begin
            vmem[pre_addr] <= pre_data;
            vwr[pre_addr]  <= 1'b1;
        end
        if (bus.vram_sel_o) begin
            bus.vram_data_i <= vram_rd(bus.vram_addr_o);
            if (bus.vram_wr_o) begin
                vmem[bus.vram_addr_o] <= merge(vram_rd(bus.vram_addr_o), bus.vram_data_o, bus.vram_wr_mask_o);
                vwr[bus.vram_addr_o]  <= 1'b1;
            end
        end
    end

    // reference memory for the randomized run
    logic [15:0] rmem [0:65535];
    bit          rwr  [0:65535];

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return rwr[a] ? rmem[a] : init_val(a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.vid_sel_i = 1'b0;      bus.vid_addr_i = 16'h0000;
        bus.reg_req_i = 1'b0;      bus.reg_wr_i = 1'b0;
        bus.reg_wr_mask_i = 4'h0;  bus.reg_addr_i = 16'h0000; bus.reg_data_i = 16'h0000;
        bus.blit_req_i = 1'b0;     bus.blit_wr_i = 1'b0;
        bus.blit_wr_mask_i = 4'h0; bus.blit_addr_i = 16'h0000; bus.blit_data_i = 16'h0000;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    function automatic logic [71:0] all_outs();
        return {bus.vram_sel_o, bus.vram_wr_o, bus.vram_wr_mask_o, bus.vram_addr_o, bus.vram_data_o,
                bus.reg_ack_o, bus.blit_ack_o, bus.rd_data_o, bus.vid_data_o};
    endfunction

    task automatic test_reset();
        logic [71:0] o;
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        o = all_outs();
        n_checks++;
        if (o !== 72'd0) $display("FAIL reset_outputs: got %h expected 0", o); else n_pass++;
        reset_n = 1'b1;
        tick();
        o = all_outs();
        n_checks++;
        if (o !== 72'd0) $display("FAIL after_release_outputs: got %h expected 0", o); else n_pass++;
        pre_en = 1'b1; pre_addr = 16'h1234; pre_data = 16'hBEEF;
        tick();
        pre_en = 1'b0;
        bus.reg_req_i = 1'b1; bus.reg_wr_i = 1'b0; bus.reg_addr_i = 16'h1234; bus.reg_wr_mask_i = 4'hF;
        tick();
        n_checks++;
        if ({bus.vram_sel_o, bus.vram_wr_o, bus.vram_wr_mask_o, bus.vram_addr_o} !== {1'b1, 1'b0, 4'h0, 16'h1234})
            $display("FAIL first_read_strobe: got sel=%b wr=%b mask=%h addr=%h expected 1 0 0 1234",
                     bus.vram_sel_o, bus.vram_wr_o, bus.vram_wr_mask_o, bus.vram_addr_o);
        else n_pass++;
        n_checks++;
        if (bus.reg_ack_o !== 1'b0) $display("FAIL first_read_early_ack: got %b expected 0", bus.reg_ack_o); else n_pass++;
        tick();
        n_checks++;
        if ({bus.reg_ack_o, bus.rd_data_o} !== {1'b1, 16'hBEEF})
            $display("FAIL first_read_ack: got ack=%b data=%h expected 1 beef", bus.reg_ack_o, bus.rd_data_o);
        else n_pass++;
        bus.reg_req_i = 1'b0;
        tick();
        n_checks++;
        if ({bus.reg_ack_o, bus.vram_sel_o, bus.rd_data_o} !== {1'b0, 1'b0, 16'hBEEF})
            $display("FAIL first_read_after: got ack=%b sel=%b data=%h expected 0 0 beef",
                     bus.reg_ack_o, bus.vram_sel_o, bus.rd_data_o);
        else n_pass++;
    endtask

    task automatic test_masked_write();
        logic [15:0] expv;
        bus.reg_req_i = 1'b1; bus.reg_wr_i = 1'b1; bus.reg_addr_i = 16'h0010;
        bus.reg_data_i = 16'hA5A5; bus.reg_wr_mask_i = 4'b0011;
        tick();
        n_checks++;
        if ({bus.vram_sel_o, bus.vram_wr_o, bus.vram_wr_mask_o, bus.vram_addr_o, bus.vram_data_o} !==
            {1'b1, 1'b1, 4'b0011, 16'h0010, 16'hA5A5})
            $display("FAIL masked_write_strobe: got sel=%b wr=%b mask=%b addr=%h data=%h expected 1 1 0011 0010 a5a5",
                     bus.vram_sel_o, bus.vram_wr_o, bus.vram_wr_mask_o, bus.vram_addr_o, bus.vram_data_o);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.reg_ack_o, bus.vram_sel_o} !== 2'b10)
            $display("FAIL masked_write_ack: got ack=%b sel=%b expected 1 0", bus.reg_ack_o, bus.vram_sel_o);
        else n_pass++;
        bus.reg_req_i = 1'b0;
        tick();
        bus.reg_req_i = 1'b1; bus.reg_wr_i = 1'b0;
        tick();
        tick();
        expv = merge(init_val(16'h0010), 16'hA5A5, 4'b0011);
        n_checks++;
        if ({bus.reg_ack_o, bus.rd_data_o} !== {1'b1, expv})
            $display("FAIL masked_write_readback: got ack=%b data=%h expected 1 %h", bus.reg_ack_o, bus.rd_data_o, expv);
        else n_pass++;
        bus.reg_req_i = 1'b0;
        tick();
    endtask

    task automatic test_video_burst();
        logic [15:0] va [4];
        int          c;
        for (int i = 0; i < 4; i++) va[i] = 16'h8000 | 16'($urandom_range(0, 63));
        bus.reg_wr_i = 1'b0; bus.reg_addr_i = 16'h0200;
        for (int k = 0; k < 8; k++) begin
            bus.vid_sel_i  = (k < 4);
            bus.vid_addr_i = (k < 4) ? va[k] : 16'h0000;
            bus.reg_req_i  = (k < 6);
            tick();
            c = k + 1;
            n_checks++;
            if (bus.vram_sel_o !== (c <= 5)) $display("FAIL vid_burst_sel c%0d: got %b expected %b", c, bus.vram_sel_o, (c <= 5));
            else n_pass++;
            if (c <= 4) begin
                n_checks++;
                if ({bus.vram_addr_o, bus.vram_wr_o, bus.vram_wr_mask_o} !== {va[c-1], 1'b0, 4'h0})
                    $display("FAIL vid_burst_addr c%0d: got %h/%b/%h expected %h/0/0", c,
                             bus.vram_addr_o, bus.vram_wr_o, bus.vram_wr_mask_o, va[c-1]);
                else n_pass++;
            end
            if (c == 5) begin
                n_checks++;
                if (bus.vram_addr_o !== 16'h0200) $display("FAIL vid_burst_reg_slot: got %h expected 0200", bus.vram_addr_o);
                else n_pass++;
            end
            n_checks++;
            if (bus.reg_ack_o !== (c == 6)) $display("FAIL vid_burst_ack c%0d: got %b expected %b", c, bus.reg_ack_o, (c == 6));
            else n_pass++;
            if (c >= 3 && c <= 6) begin
                n_checks++;
                if (bus.vid_data_o !== init_val(va[c-3]))
                    $display("FAIL vid_burst_data c%0d: got %h expected %h", c, bus.vid_data_o, init_val(va[c-3]));
                else n_pass++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_access();
        logic [71:0] o;
        bus.reg_req_i = 1'b1; bus.reg_wr_i = 1'b0; bus.reg_addr_i = 16'h0300;
        tick();
        reset_n = 1'b0;
        bus.reg_req_i = 1'b0;
        #1;
        o = all_outs();
        n_checks++;
        if (o !== 72'd0) $display("FAIL mid_reset_outputs: got %h expected 0", o); else n_pass++;
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({bus.reg_ack_o, bus.vram_sel_o} !== 2'b00)
                $display("FAIL mid_reset_no_ack: got ack=%b sel=%b expected 0 0", bus.reg_ack_o, bus.vram_sel_o);
            else n_pass++;
        end
    endtask

`ifdef XOSERA_BLIT_PORT_EN
    task automatic test_collision();
        do_reset();
        bus.vid_sel_i = 1'b1; bus.vid_addr_i = 16'h0400;
        bus.reg_req_i = 1'b1; bus.reg_addr_i = 16'h0500;
        bus.blit_req_i = 1'b1; bus.blit_addr_i = 16'h0600;
        tick();
        bus.vid_sel_i = 1'b0;
        n_checks++;
        if ({bus.vram_sel_o, bus.vram_addr_o} !== {1'b1, 16'h0400}) $display("FAIL coll_vid: got %b %h expected 1 0400", bus.vram_sel_o, bus.vram_addr_o); else n_pass++;
        tick();
        n_checks++;
        if ({bus.vram_sel_o, bus.vram_addr_o} !== {1'b1, 16'h0500}) $display("FAIL coll_reg: got %b %h expected 1 0500", bus.vram_sel_o, bus.vram_addr_o); else n_pass++;
        tick();
        n_checks++;
        if ({bus.vram_sel_o, bus.vram_addr_o, bus.reg_ack_o} !== {1'b1, 16'h0600, 1'b1}) $display("FAIL coll_blit: got %b %h ack=%b expected 1 0600 1", bus.vram_sel_o, bus.vram_addr_o, bus.reg_ack_o); else n_pass++;
        bus.reg_req_i = 1'b0;
        tick();
        n_checks++;
        if ({bus.blit_ack_o, bus.vram_sel_o} !== 2'b10) $display("FAIL coll_blit_ack: got ack=%b sel=%b expected 1 0", bus.blit_ack_o, bus.vram_sel_o); else n_pass++;
        bus.blit_req_i = 1'b0;
        tick();
        bus.reg_req_i = 1'b1; bus.reg_addr_i = 16'h0700;
        bus.blit_req_i = 1'b1; bus.blit_addr_i = 16'h0800;
        tick();
        n_checks++;
        if ({bus.vram_sel_o, bus.vram_addr_o} !== {1'b1, 16'h0800}) $display("FAIL pair2_blit_first: got %b %h expected 1 0800", bus.vram_sel_o, bus.vram_addr_o); else n_pass++;
        tick();
        n_checks++;
        if ({bus.vram_sel_o, bus.vram_addr_o, bus.blit_ack_o} !== {1'b1, 16'h0700, 1'b1}) $display("FAIL pair2_reg_second: got %b %h ack=%b expected 1 0700 1", bus.vram_sel_o, bus.vram_addr_o, bus.blit_ack_o); else n_pass++;
        bus.blit_req_i = 1'b0;
        tick();
        n_checks++;
        if ({bus.reg_ack_o, bus.vram_sel_o} !== 2'b10) $display("FAIL pair2_reg_ack: got ack=%b sel=%b expected 1 0", bus.reg_ack_o, bus.vram_sel_o); else n_pass++;
        clear_inputs();
        tick();
    endtask
`else
    task automatic test_blit_disabled();
        int c;
        do_reset();
        bus.blit_req_i = 1'b1; bus.blit_addr_i = 16'h0600;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({bus.vram_sel_o, bus.blit_ack_o} !== 2'b00) $display("FAIL blit_off_idle: got sel=%b ack=%b expected 0 0", bus.vram_sel_o, bus.blit_ack_o); else n_pass++;
        end
        bus.reg_req_i = 1'b1; bus.reg_addr_i = 16'h0500;
        for (int k = 0; k < 9; k++) begin
            tick();
            c = k + 1;
            n_checks++;
            if ({bus.vram_sel_o, bus.reg_ack_o, bus.blit_ack_o} !== {(c % 3 == 1), (c % 3 == 2), 1'b0})
                $display("FAIL blit_off_reg_slots c%0d: got sel=%b rack=%b back=%b expected %b %b 0", c,
                         bus.vram_sel_o, bus.reg_ack_o, bus.blit_ack_o, (c % 3 == 1), (c % 3 == 2));
            else n_pass++;
        end
        clear_inputs();
        tick();
        tick();
    endtask
`endif

    // expected schedule, indexed by cycle
    bit          e_sel  [NC+4];
    logic        e_wr   [NC+4];
    logic [3:0]  e_mask [NC+4];
    logic [15:0] e_addr [NC+4];
    logic [15:0] e_data [NC+4];
    bit          e_rack [NC+4];
    bit          e_back [NC+4];
    bit          e_rd_v [NC+4];
    logic [15:0] e_rd   [NC+4];
    bit          e_vid_v[NC+4];
    logic [15:0] e_vid  [NC+4];

    task automatic test_random();
        bit          r_req [2];
        logic        r_wr  [2];
        logic [3:0]  r_mask[2];
        logic [15:0] r_addr[2];
        logic [15:0] r_data[2];
        int          busy_until[2];
        int          ack_cycle[2];
        bit          el[2];
        bit          v;
        bit          lw_blit;
        logic [15:0] va;
        logic [15:0] cur_vid;
        int          win;
        for (int i = 0; i < NC + 4; i++) begin
            e_sel[i] = 1'b0; e_rack[i] = 1'b0; e_back[i] = 1'b0; e_rd_v[i] = 1'b0; e_vid_v[i] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 1'b0; busy_until[p] = -10; ack_cycle[p] = -10;
        end
        lw_blit = 1'b1;
        cur_vid = 16'h0000;
        do_reset();
        for (int c = 0; c < NC; c++) begin
            n_checks++;
            if (bus.vram_sel_o !== e_sel[c]) $display("FAIL rnd_sel c%0d: got %b expected %b", c, bus.vram_sel_o, e_sel[c]); else n_pass++;
            if (e_sel[c]) begin
                n_checks++;
                if ({bus.vram_wr_o, bus.vram_wr_mask_o, bus.vram_addr_o} !== {e_wr[c], e_mask[c], e_addr[c]})
                    $display("FAIL rnd_cmd c%0d: got %b/%h/%h expected %b/%h/%h", c, bus.vram_wr_o, bus.vram_wr_mask_o,
                             bus.vram_addr_o, e_wr[c], e_mask[c], e_addr[c]);
                else n_pass++;
                if (e_wr[c]) begin
                    n_checks++;
                    if (bus.vram_data_o !== e_data[c]) $display("FAIL rnd_wdata c%0d: got %h expected %h", c, bus.vram_data_o, e_data[c]); else n_pass++;
                end
            end
            n_checks++;
            if ({bus.reg_ack_o, bus.blit_ack_o} !== {e_rack[c], e_back[c]})
                $display("FAIL rnd_ack c%0d: got %b%b expected %b%b", c, bus.reg_ack_o, bus.blit_ack_o, e_rack[c], e_back[c]);
            else n_pass++;
            if (e_rd_v[c]) begin
                n_checks++;
                if (bus.rd_data_o !== e_rd[c]) $display("FAIL rnd_rdata c%0d: got %h expected %h", c, bus.rd_data_o, e_rd[c]); else n_pass++;
            end
            if (e_vid_v[c]) cur_vid = e_vid[c];
            n_checks++;
            if (bus.vid_data_o !== cur_vid) $display("FAIL rnd_vid c%0d: got %h expected %h", c, bus.vid_data_o, cur_vid); else n_pass++;

            // requesters: hold operands until ack, then drop or re-issue the cycle after
            for (int p = 0; p < 2; p++) begin
                if (!r_req[p] || ack_cycle[p] == c - 1) begin
                    r_req[p] = ($urandom_range(0, 1) == 1);
                    r_wr[p]   = 1'($urandom_range(0, 1));
                    r_mask[p] = 4'($urandom_range(0, 15));
                    r_addr[p] = 16'h8000 | 16'($urandom_range(0, 31));
                    r_data[p] = 16'($urandom);
                end
            end
            v  = ($urandom_range(0, 3) == 0);
            va = 16'h8000 | 16'($urandom_range(0, 63));
            bus.vid_sel_i = v; bus.vid_addr_i = va;
            bus.reg_req_i = r_req[0]; bus.reg_wr_i = r_wr[0]; bus.reg_wr_mask_i = r_mask[0];
            bus.reg_addr_i = r_addr[0]; bus.reg_data_i = r_data[0];
            bus.blit_req_i = r_req[1]; bus.blit_wr_i = r_wr[1]; bus.blit_wr_mask_i = r_mask[1];
            bus.blit_addr_i = r_addr[1]; bus.blit_data_i = r_data[1];

            // model: video first, then eligible ports, ties to the previous loser
            el[0] = r_req[0] && (c > busy_until[0]);
            el[1] = r_req[1] && (c > busy_until[1]) && BLIT_EN;
            win = -1;
            if (v) win = 2;
            else if (el[0] && el[1]) begin
                win = lw_blit ? 0 : 1;
                lw_blit = (win == 1);
            end
            else if (el[0]) win = 0;
            else if (el[1]) win = 1;
            if (win == 2) begin
                e_sel[c+1] = 1'b1; e_wr[c+1] = 1'b0; e_mask[c+1] = 4'h0; e_addr[c+1] = va;
                e_vid_v[c+3] = 1'b1; e_vid[c+3] = ref_rd(va);
            end else if (win >= 0) begin
                e_sel[c+1] = 1'b1; e_wr[c+1] = r_wr[win];
                e_mask[c+1] = r_wr[win] ? r_mask[win] : 4'h0;
                e_addr[c+1] = r_addr[win]; e_data[c+1] = r_data[win];
                busy_until[win] = c + 2;
                ack_cycle[win] = c + 2;
                if (win == 0) e_rack[c+2] = 1'b1; else e_back[c+2] = 1'b1;
                if (!r_wr[win]) begin
                    e_rd_v[c+2] = 1'b1; e_rd[c+2] = ref_rd(r_addr[win]);
                end else begin
                    rmem[r_addr[win]] = merge(ref_rd(r_addr[win]), r_data[win], r_mask[win]);
                    rwr[r_addr[win]] = 1'b1;
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_masked_write();
        test_video_burst();
        test_reset_mid_access();
`ifdef XOSERA_BLIT_PORT_EN
        test_collision();
`else
        test_blit_disabled();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
